// File: rtl/video_pkg.sv
// Shared widths, capture FSM encoding and pixel helpers for the video capture path.
// Pure declarations; no logic, no latency.
package video_pkg;

  localparam int DATA_W = 24;
  localparam int COL_W  = 12;
  localparam int ROW_W  = 11;
  localparam int ADDR_W = 22;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // r+g+b of one {r,g,b} pixel; 10 bits holds 3*255.
  function automatic logic [9:0] pix_sum(input logic [DATA_W-1:0] rgb);
    return {2'b00, rgb[23:16]} + {2'b00, rgb[15:8]} + {2'b00, rgb[7:0]};
  endfunction

endpackage

// File: rtl/video_edge_det.sv
// Registers the vs/hs/de/rgb stream once, then derives vs-rise, de-rise and de-fall pulses
// from the registered copies against a second delay stage. 1 cycle latency, no backpressure.
module video_edge_det #(
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              vs,
  input  logic              hs,
  input  logic              de,
  input  logic [DATA_W-1:0] rgb,
  output logic              hs_q,
  output logic              de_q,
  output logic [DATA_W-1:0] rgb_q,
  output logic              vs_rise,
  output logic              de_rise,
  output logic              de_fall
);

  logic vs_q;
  logic vs_d;
  logic de_d;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      vs_q  <= 1'b0;
      hs_q  <= 1'b0;
      de_q  <= 1'b0;
      rgb_q <= '0;
      vs_d  <= 1'b0;
      de_d  <= 1'b0;
    end else begin
      vs_q  <= vs;
      hs_q  <= hs;
      de_q  <= de;
      rgb_q <= rgb;
      vs_d  <= vs_q;
      de_d  <= de_q;
    end
  end

  assign vs_rise = vs_q & ~vs_d;
  assign de_rise = de_q & ~de_d;
  assign de_fall = ~de_q & de_d;

endmodule

// File: rtl/video_rx_capture.sv
// Captures one full vs/hs/de frame on request into linear frame-memory writes (wr_en 2 clk after de),
// measures and checks geometry; no backpressure. Optional checksum: VIDEO_RX_CAPTURE_SUM_EN.
module video_rx_capture
  import video_pkg::*;
(
  input  logic              clk,
  input  logic              rst_b,
  input  logic              vs_in,
  input  logic              hs_in,
  input  logic              de_in,
  input  logic [DATA_W-1:0] rgb_data_in,
  input  logic [COL_W-1:0]  col_size,
  input  logic [ROW_W-1:0]  row_size,
  input  logic              capture_req,
  output logic              busy,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              frame_done,
  output logic [COL_W-1:0]  meas_col,
  output logic [ROW_W-1:0]  meas_row,
  output logic              err_col,
  output logic              err_row,
  output logic [31:0]       frame_sum
);

  logic              hs_q;
  logic              de_q;
  logic [DATA_W-1:0] rgb_q;
  logic              vs_rise;
  logic              de_rise;
  logic              de_fall;

  video_edge_det #(.DATA_W(DATA_W)) u_edge_det (
    .clk     (clk),
    .rst_b   (rst_b),
    .vs      (vs_in),
    .hs      (hs_in),
    .de      (de_in),
    .rgb     (rgb_data_in),
    .hs_q    (hs_q),
    .de_q    (de_q),
    .rgb_q   (rgb_q),
    .vs_rise (vs_rise),
    .de_rise (de_rise),
    .de_fall (de_fall)
  );

  // hs travels with the pipeline so it stays aligned, but nothing here counts on it.
  logic unused_hs;
  assign unused_hs = hs_q;

  state_t            state;
  logic [ADDR_W-1:0] addr_cnt;
  logic [ADDR_W-1:0] frame_limit;
  logic [COL_W-1:0]  col_cnt;
  logic [COL_W-1:0]  col_next;
  logic [ROW_W-1:0]  row_cnt;
  logic [ROW_W-1:0]  row_next;
  logic [ROW_W-1:0]  row_final;
  logic              in_line;
  logic              cap_start;
  logic              wr_fire;
  logic              line_close;

  assign frame_limit = ADDR_W'(col_size) * ADDR_W'(row_size);
  assign cap_start   = (state == ARMED) && vs_rise;
  assign wr_fire     = (state == CAPTURE) && de_q && (addr_cnt < frame_limit);
  // A line closes on de fall, or is cut short by the frame-ending vs while de is still high.
  assign line_close  = (de_fall && in_line) || (vs_rise && de_q);
  assign row_next    = (row_cnt == '1) ? row_cnt : row_cnt + 1'b1;
  assign row_final   = line_close ? row_next : row_cnt;

  always_comb begin
    col_next = col_cnt;
    if (de_rise) begin
      col_next = COL_W'(1);
    end else if (de_q && (col_cnt != '1)) begin
      col_next = col_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state      <= IDLE;
      busy       <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      meas_col   <= '0;
      meas_row   <= '0;
      err_col    <= 1'b0;
      err_row    <= 1'b0;
      addr_cnt   <= '0;
      col_cnt    <= '0;
      row_cnt    <= '0;
      in_line    <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (capture_req) begin
            state <= ARMED;
            busy  <= 1'b1;
          end
        end
        ARMED: begin
          if (cap_start) begin
            state    <= CAPTURE;
            addr_cnt <= '0;
            col_cnt  <= '0;
            row_cnt  <= '0;
            in_line  <= 1'b0;
            meas_col <= '0;
            meas_row <= '0;
            err_col  <= 1'b0;
            err_row  <= 1'b0;
          end
        end
        CAPTURE: begin
          col_cnt <= col_next;
          if (de_rise) begin
            in_line <= 1'b1;
          end
          if (wr_fire) begin
            wr_en    <= 1'b1;
            wr_addr  <= addr_cnt;
            wr_data  <= rgb_q;
            addr_cnt <= addr_cnt + 1'b1;
          end else if (de_q) begin
            err_row <= 1'b1;
          end
          if (line_close) begin
            in_line <= 1'b0;
            row_cnt <= row_next;
            if (row_cnt == '0) begin
              meas_col <= col_next;
            end
            if (col_next != col_size) begin
              err_col <= 1'b1;
            end
          end
          if (vs_rise) begin
            state      <= DONE;
            frame_done <= 1'b1;
            meas_row   <= row_final;
            if (row_final != row_size) begin
              err_row <= 1'b1;
            end
            if (de_q) begin
              err_col <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef VIDEO_RX_CAPTURE_SUM_EN
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      frame_sum <= '0;
    end else if (cap_start) begin
      frame_sum <= '0;
    end else if (wr_fire) begin
      frame_sum <= frame_sum + 32'(pix_sum(rgb_q));
    end
  end
`else
  assign frame_sum = '0;
`endif

endmodule

// File: tb/tb_video_rx_capture.sv
// Directed and randomized frame captures checked against a frame-level reference model.
module tb_video_rx_capture;
  import video_pkg::*;

  logic              clk = 1'b0;
  logic              rst_b = 1'b0;
  logic              vs_in = 1'b0;
  logic              hs_in = 1'b0;
  logic              de_in = 1'b0;
  logic [DATA_W-1:0] rgb_data_in = '0;
  logic [COL_W-1:0]  col_size = '0;
  logic [ROW_W-1:0]  row_size = '0;
  logic              capture_req = 1'b0;
  logic              busy;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              frame_done;
  logic [COL_W-1:0]  meas_col;
  logic [ROW_W-1:0]  meas_row;
  logic              err_col;
  logic              err_row;
  logic [31:0]       frame_sum;

  video_rx_capture dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .vs_in       (vs_in),
    .hs_in       (hs_in),
    .de_in       (de_in),
    .rgb_data_in (rgb_data_in),
    .col_size    (col_size),
    .row_size    (row_size),
    .capture_req (capture_req),
    .busy        (busy),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .frame_done  (frame_done),
    .meas_col    (meas_col),
    .meas_row    (meas_row),
    .err_col     (err_col),
    .err_row     (err_row),
    .frame_sum   (frame_sum)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                cyc;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  bit          exp_now;
  int          compared = 0;
  int          mismatched = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  logic [31:0] s_col, s_row, s_ec, s_er, s_sum, s_busy;

  // Frame description and model state
  int          n_lines = 0;
  int          line_len[16];
  bit          partial_end = 0;
  int          pix_mode = 0;
  int          ramp = 0;
  bit          exp_on = 0;
  int          req_line = -1;
  int          m_addr = 0;
  int          m_limit = 0;
  logic [31:0] m_sum = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  always begin
    @(posedge clk);
    #1;
    cyc = cyc + 1;
    if (rst_b) begin
      if (frame_done) begin
        done_cnt = done_cnt + 1;
        s_col  = 32'(meas_col);
        s_row  = 32'(meas_row);
        s_ec   = 32'(err_col);
        s_er   = 32'(err_row);
        s_sum  = frame_sum;
        s_busy = 32'(busy);
      end
      exp_now = (exp_q.size() != 0) && (exp_q[0].cyc <= cyc);
      if (wr_en || exp_now) begin
        chk($sformatf("wr_en@%0d", cyc), 32'(wr_en), 32'(exp_now));
        if (exp_now) begin
          mon_e = exp_q.pop_front();
          if (wr_en) begin
            chk($sformatf("wr_addr@%0d", cyc), 32'(wr_addr), 32'(mon_e.addr));
            chk($sformatf("wr_data@%0d", cyc), 32'(wr_data), 32'(mon_e.data));
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  function automatic logic [DATA_W-1:0] next_pixel();
    logic [DATA_W-1:0] p;
    case (pix_mode)
      0:       begin p = DATA_W'(ramp); ramp++; end
      1:       p = 24'h010203;
      default: p = DATA_W'($urandom);
    endcase
    return p;
  endfunction

  task automatic drive_pixel();
    wr_t e;
    rgb_data_in = next_pixel();
    de_in = 1'b1;
    if (exp_on && (m_addr < m_limit)) begin
      e.cyc  = cyc + 2;
      e.addr = ADDR_W'(m_addr);
      e.data = rgb_data_in;
      exp_q.push_back(e);
      m_sum = m_sum + 32'(rgb_data_in[23:16]) + 32'(rgb_data_in[15:8]) + 32'(rgb_data_in[7:0]);
      m_addr++;
    end
  endtask

  task automatic send_frame();
    vs_in = 1'b1; idle(2); vs_in = 1'b0; idle(3);
    for (int l = 0; l < n_lines; l++) begin
      if (req_line == l) capture_req = 1'b1;
      hs_in = 1'b1; tick(); capture_req = 1'b0; tick(); hs_in = 1'b0; idle(2);
      for (int p = 0; p < line_len[l]; p++) begin
        drive_pixel();
        if (partial_end && (l == n_lines - 1) && (p == line_len[l] - 1)) vs_in = 1'b1;
        tick();
      end
      de_in = 1'b0; rgb_data_in = '0;
      if (partial_end && (l == n_lines - 1)) begin
        idle(1); vs_in = 1'b0;
      end
      idle(3);
    end
  endtask

  task automatic end_frame();
    vs_in = 1'b1; idle(2); vs_in = 1'b0; idle(4);
  endtask

  task automatic set_uniform(input int n, input int len);
    n_lines = n;
    for (int i = 0; i < 16; i++) line_len[i] = len;
  endtask

  task automatic start_model();
    m_addr  = 0;
    m_sum   = '0;
    m_limit = int'(col_size) * int'(row_size);
  endtask

  task automatic check_result(input string tag, input int d0);
    int tot = 0;
    bit ec = partial_end;
    bit er;
    for (int i = 0; i < n_lines; i++) begin
      tot += line_len[i];
      if (line_len[i] != int'(col_size)) ec = 1'b1;
    end
    er = (n_lines != int'(row_size)) || (tot > m_limit);
    chk({tag, ".done_pulses"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, ".meas_col"}, s_col, 32'(line_len[0]));
    chk({tag, ".meas_row"}, s_row, 32'(n_lines));
    chk({tag, ".err_col"}, s_ec, 32'(ec));
    chk({tag, ".err_row"}, s_er, 32'(er));
    chk({tag, ".busy_at_done"}, s_busy, 32'd1);
`ifdef VIDEO_RX_CAPTURE_SUM_EN
    chk({tag, ".frame_sum"}, s_sum, m_sum);
`else
    chk({tag, ".frame_sum"}, s_sum, 32'd0);
`endif
    chk({tag, ".busy_after"}, 32'(busy), 32'd0);
  endtask

  task automatic run_capture(input string tag);
    int d0 = done_cnt;
    start_model();
    exp_on = 1'b1;
    capture_req = 1'b1; tick(); capture_req = 1'b0; idle(2);
    send_frame();
    if (!partial_end) end_frame(); else idle(4);
    check_result(tag, d0);
    exp_on = 1'b0; partial_end = 1'b0; req_line = -1;
  endtask

  initial begin
    int d0;
    tick(); tick();
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.wr_en", 32'(wr_en), 32'd0);
    chk("rst.wr_addr", 32'(wr_addr), 32'd0);
    chk("rst.wr_data", 32'(wr_data), 32'd0);
    chk("rst.frame_done", 32'(frame_done), 32'd0);
    chk("rst.meas_col", 32'(meas_col), 32'd0);
    chk("rst.meas_row", 32'(meas_row), 32'd0);
    chk("rst.err_col", 32'(err_col), 32'd0);
    chk("rst.err_row", 32'(err_row), 32'd0);
    chk("rst.frame_sum", frame_sum, 32'd0);
    rst_b = 1'b1; idle(3);

    col_size = 12'd8; row_size = 11'd4;
    set_uniform(4, 8); pix_mode = 0; ramp = 0;
    run_capture("geom");

    set_uniform(4, 8); line_len[1] = 7; pix_mode = 2;
    run_capture("short_line");

    row_size = 11'd5; set_uniform(4, 8);
    run_capture("row_mismatch");

    row_size = 11'd3; set_uniform(4, 8);
    run_capture("overflow");

    row_size = 11'd4; set_uniform(4, 8); line_len[3] = 5; partial_end = 1'b1;
    run_capture("partial_tail");

    set_uniform(4, 8); req_line = 2;
    run_capture("req_in_capture");
    d0 = done_cnt; exp_on = 1'b0; send_frame(); end_frame();
    chk("req_in_capture.no_second_done", 32'(done_cnt - d0), 32'd0);
    chk("req_in_capture.idle_busy", 32'(busy), 32'd0);

    d0 = done_cnt; exp_on = 1'b0; req_line = 1; set_uniform(4, 8);
    send_frame();
    req_line = -1; start_model(); exp_on = 1'b1;
    send_frame(); end_frame();
    check_result("req_idle_midframe", d0);
    exp_on = 1'b0;

    set_uniform(4, 8); pix_mode = 1;
    run_capture("checksum");

    d0 = done_cnt; start_model(); exp_on = 1'b1; pix_mode = 2;
    capture_req = 1'b1; tick(); capture_req = 1'b0; idle(2);
    vs_in = 1'b1; idle(2); vs_in = 1'b0; idle(3);
    for (int p = 0; p < 5; p++) begin drive_pixel(); tick(); end
    chk("reset.wr_en_before", 32'(wr_en), 32'd1);
    chk("reset.busy_before", 32'(busy), 32'd1);
    rst_b = 1'b0; exp_q.delete(); exp_on = 1'b0;
    #1;
    chk("reset.wr_en", 32'(wr_en), 32'd0);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.frame_done", 32'(frame_done), 32'd0);
    de_in = 1'b0; idle(2); rst_b = 1'b1; idle(2);
    set_uniform(3, 8); send_frame(); end_frame();
    chk("reset.no_done", 32'(done_cnt - d0), 32'd0);
    chk("reset.stays_idle", 32'(busy), 32'd0);

    for (int t = 0; t < 4; t++) begin
      col_size = COL_W'($urandom_range(3, 10));
      row_size = ROW_W'($urandom_range(2, 6));
      n_lines = int'(row_size) + int'($urandom_range(0, 2)) - 1;
      for (int i = 0; i < 16; i++)
        line_len[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : int'(col_size);
      pix_mode = 2;
      run_capture($sformatf("rnd%0d", t));
    end

    idle(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
